// File: rtl/multi_blob_tracker_pkg.sv
// Shared types, width helpers and accumulator reset values for multi_blob_tracker.
package blob_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  // Maximum accumulators reset to zero; minimum accumulators reset to extent-1 via min_rst().
  localparam int MAX_RST = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    EMIT = 2'd2
  } state_e;

  function automatic int x_w(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int y_w(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

  function automatic int cnt_w(input int img_width, input int img_height);
    return $clog2(img_width * img_height + 1);
  endfunction

  function automatic int sum_w(input int img_width, input int img_height);
    longint px;
    int     wx;
    int     wy;
    px = longint'(img_width) * longint'(img_height);
    wx = $clog2(px * longint'(img_width));
    wy = $clog2(px * longint'(img_height));
    return (wx > wy) ? wx : wy;
  endfunction

  function automatic int min_rst(input int extent);
    return extent - 1;
  endfunction

endpackage

// File: rtl/multi_blob_tracker_if.sv
// Pixel-in / result-out bus of multi_blob_tracker; master drives pixels and ready.
interface multi_blob_tracker_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int CNT_W  = 19
);
  logic              i_valid;
  logic              i_sof;
  logic [NUM_CH-1:0] i_mask;
  logic              o_valid;
  logic              i_ready;
  logic [CH_W-1:0]   o_ch;
  logic [X_W-1:0]    o_min_x;
  logic [X_W-1:0]    o_max_x;
  logic [Y_W-1:0]    o_min_y;
  logic [Y_W-1:0]    o_max_y;
  logic [X_W-1:0]    o_cx;
  logic [Y_W-1:0]    o_cy;
  logic [CNT_W-1:0]  o_count;
  logic              o_qualified;
  logic              o_last;
  logic              o_overflow;

  modport master (
    output i_valid, i_sof, i_mask, i_ready,
    input  o_valid, o_ch, o_min_x, o_max_x, o_min_y, o_max_y,
           o_cx, o_cy, o_count, o_qualified, o_last, o_overflow
  );

  modport slave (
    input  i_valid, i_sof, i_mask, i_ready,
    output o_valid, o_ch, o_min_x, o_max_x, o_min_y, o_max_y,
           o_cx, o_cy, o_count, o_qualified, o_last, o_overflow
  );
endinterface

// File: rtl/multi_blob_tracker_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; used by the CENTROID_MEAN_EN build.
module seq_divider #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [W:0]    shifted, diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (i_start) begin
      rem_d  = '0;
      quo_d  = i_dividend;
      dvs_d  = i_divisor;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // A negative trial difference restores the shifted remainder.
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_quotient = quo_q;
endmodule

// File: rtl/multi_blob_tracker.sv
// Per-class bounding box, count and centroid tracker; streams one result beat per channel per frame.
// Define CENTROID_MEAN_EN for a true mean centroid (sum/count via a shared divider) instead of the bbox midpoint.
module multi_blob_tracker
  import blob_pkg::*;
#(
  parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT,
  parameter int NUM_CH          = 4,
  parameter int PIXEL_THRESHOLD = 1000
) (
  input logic i_clk,
  input logic i_rst,
  multi_blob_tracker_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int X_W   = x_w(IMG_WIDTH);
  localparam int Y_W   = y_w(IMG_HEIGHT);
  localparam int CNT_W = cnt_w(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [X_W-1:0]   X_LAST    = X_W'(min_rst(IMG_WIDTH));
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(min_rst(IMG_HEIGHT));
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESHOLD = CNT_W'(PIXEL_THRESHOLD);
`ifdef CENTROID_MEAN_EN
  localparam int SUM_W = sum_w(IMG_WIDTH, IMG_HEIGHT);
`endif

  logic [X_W-1:0] x_q, x_d, cur_x;
  logic [Y_W-1:0] y_q, y_d, cur_y;
  logic           sof_pix, frame_end, snap_pend_q, snap_pend_d, clear_acc, snap_load;
  state_e         state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic           overflow_q, overflow_d;

  logic [CNT_W-1:0] s_cnt   [NUM_CH];
  logic [X_W-1:0]   s_min_x [NUM_CH];
  logic [X_W-1:0]   s_max_x [NUM_CH];
  logic [Y_W-1:0]   s_min_y [NUM_CH];
  logic [Y_W-1:0]   s_max_y [NUM_CH];
`ifdef CENTROID_MEAN_EN
  logic [SUM_W-1:0] s_sum_x [NUM_CH];
  logic [SUM_W-1:0] s_sum_y [NUM_CH];
`endif

  always_comb begin
    sof_pix     = bus.i_valid & bus.i_sof;
    cur_x       = sof_pix ? '0 : x_q;
    cur_y       = sof_pix ? '0 : y_q;
    frame_end   = bus.i_valid && (cur_x == X_LAST) && (cur_y == Y_LAST);
    snap_pend_d = frame_end;
    x_d         = x_q;
    y_d         = y_q;
    if (bus.i_valid) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
      end else begin
        x_d = cur_x + X_W'(1);
        y_d = cur_y;
      end
    end
    // The snapshot cycle and any start-of-frame pixel both restart accumulation.
    clear_acc = sof_pix | snap_pend_q;
    snap_load = snap_pend_q & (state_q == IDLE);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, scnt_q, scnt_d;
    logic [X_W-1:0]   mnx_q, mnx_d, mxx_q, mxx_d, smnx_q, smnx_d, smxx_q, smxx_d;
    logic [Y_W-1:0]   mny_q, mny_d, mxy_q, mxy_d, smny_q, smny_d, smxy_q, smxy_d;
    logic             hit;
`ifdef CENTROID_MEAN_EN
    logic [SUM_W-1:0] sx_q, sx_d, sy_q, sy_d, ssx_q, ssx_d, ssy_q, ssy_d;
`endif

    always_comb begin
      hit    = bus.i_valid & bus.i_mask[gi];
      cnt_d  = clear_acc ? '0 : cnt_q;
      mnx_d  = clear_acc ? X_LAST : mnx_q;
      mxx_d  = clear_acc ? X_W'(MAX_RST) : mxx_q;
      mny_d  = clear_acc ? Y_LAST : mny_q;
      mxy_d  = clear_acc ? Y_W'(MAX_RST) : mxy_q;
      scnt_d = scnt_q;
      smnx_d = smnx_q;
      smxx_d = smxx_q;
      smny_d = smny_q;
      smxy_d = smxy_q;
      if (hit) begin
        if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_W'(1);
        if (cur_x < mnx_d) mnx_d = cur_x;
        if (cur_x > mxx_d) mxx_d = cur_x;
        if (cur_y < mny_d) mny_d = cur_y;
        if (cur_y > mxy_d) mxy_d = cur_y;
      end
      if (snap_load) begin
        scnt_d = cnt_q;
        smnx_d = (cnt_q == '0) ? '0 : mnx_q;
        smxx_d = (cnt_q == '0) ? '0 : mxx_q;
        smny_d = (cnt_q == '0) ? '0 : mny_q;
        smxy_d = (cnt_q == '0) ? '0 : mxy_q;
      end
`ifdef CENTROID_MEAN_EN
      sx_d  = clear_acc ? '0 : sx_q;
      sy_d  = clear_acc ? '0 : sy_q;
      ssx_d = snap_load ? sx_q : ssx_q;
      ssy_d = snap_load ? sy_q : ssy_q;
      if (hit) begin
        sx_d = sx_d + SUM_W'(cur_x);
        sy_d = sy_d + SUM_W'(cur_y);
      end
`endif
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        cnt_q  <= '0;
        mnx_q  <= X_LAST;
        mxx_q  <= X_W'(MAX_RST);
        mny_q  <= Y_LAST;
        mxy_q  <= Y_W'(MAX_RST);
        scnt_q <= '0;
        smnx_q <= '0;
        smxx_q <= '0;
        smny_q <= '0;
        smxy_q <= '0;
`ifdef CENTROID_MEAN_EN
        sx_q   <= '0;
        sy_q   <= '0;
        ssx_q  <= '0;
        ssy_q  <= '0;
`endif
      end else begin
        cnt_q  <= cnt_d;
        mnx_q  <= mnx_d;
        mxx_q  <= mxx_d;
        mny_q  <= mny_d;
        mxy_q  <= mxy_d;
        scnt_q <= scnt_d;
        smnx_q <= smnx_d;
        smxx_q <= smxx_d;
        smny_q <= smny_d;
        smxy_q <= smxy_d;
`ifdef CENTROID_MEAN_EN
        sx_q   <= sx_d;
        sy_q   <= sy_d;
        ssx_q  <= ssx_d;
        ssy_q  <= ssy_d;
`endif
      end
    end

    assign s_cnt[gi]   = scnt_q;
    assign s_min_x[gi] = smnx_q;
    assign s_max_x[gi] = smxx_q;
    assign s_min_y[gi] = smny_q;
    assign s_max_y[gi] = smxy_q;
`ifdef CENTROID_MEAN_EN
    assign s_sum_x[gi] = ssx_q;
    assign s_sum_y[gi] = ssy_q;
`endif
  end

`ifdef CENTROID_MEAN_EN
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_dividend, div_quot;
  logic [1:0]       phase_q, phase_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;

  seq_divider #(.W(SUM_W)) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (div_start),
    .i_dividend (div_dividend),
    .i_divisor  (SUM_W'(s_cnt[ch_q])),
    .o_busy     (div_busy),
    .o_done     (div_done),
    .o_quotient (div_quot)
  );
`endif

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    overflow_d = snap_pend_q && (state_q != IDLE);
`ifdef CENTROID_MEAN_EN
    div_start    = 1'b0;
    div_dividend = s_sum_x[ch_q];
    phase_d      = phase_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
`endif
    case (state_q)
      IDLE: begin
        if (snap_pend_q) begin
          ch_d = '0;
`ifdef CENTROID_MEAN_EN
          state_d = DIV;
          phase_d = 2'd0;
`else
          state_d = EMIT;
`endif
        end
      end
`ifdef CENTROID_MEAN_EN
      DIV: begin
        // x quotient first, then y; an empty channel skips the divider entirely.
        case (phase_q)
          2'd0: begin
            if (s_cnt[ch_q] == '0) begin
              cx_d    = '0;
              cy_d    = '0;
              state_d = EMIT;
            end else begin
              div_start = 1'b1;
              phase_d   = 2'd1;
            end
          end
          2'd1: begin
            if (div_done) begin
              cx_d         = X_W'(div_quot);
              div_start    = 1'b1;
              div_dividend = s_sum_y[ch_q];
              phase_d      = 2'd2;
            end
          end
          default: begin
            if (div_done) begin
              cy_d    = Y_W'(div_quot);
              phase_d = 2'd0;
              state_d = EMIT;
            end
          end
        endcase
      end
`endif
      EMIT: begin
        if (bus.i_ready) begin
          if (ch_q == CH_LAST) begin
            state_d = IDLE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + CH_W'(1);
`ifdef CENTROID_MEAN_EN
            state_d = DIV;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q         <= '0;
      y_q         <= '0;
      snap_pend_q <= 1'b0;
      state_q     <= IDLE;
      ch_q        <= '0;
      overflow_q  <= 1'b0;
`ifdef CENTROID_MEAN_EN
      phase_q     <= 2'd0;
      cx_q        <= '0;
      cy_q        <= '0;
`endif
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      snap_pend_q <= snap_pend_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      overflow_q  <= overflow_d;
`ifdef CENTROID_MEAN_EN
      phase_q     <= phase_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
`endif
    end
  end

  logic           emit;
  logic [X_W:0]   mid_x;
  logic [Y_W:0]   mid_y;

  always_comb begin
    emit            = (state_q == EMIT);
    mid_x           = {1'b0, s_min_x[ch_q]} + {1'b0, s_max_x[ch_q]};
    mid_y           = {1'b0, s_min_y[ch_q]} + {1'b0, s_max_y[ch_q]};
    bus.o_valid     = emit;
    bus.o_ch        = emit ? ch_q : '0;
    bus.o_last      = emit && (ch_q == CH_LAST);
    bus.o_count     = emit ? s_cnt[ch_q] : '0;
    bus.o_qualified = emit && (s_cnt[ch_q] >= THRESHOLD);
    bus.o_min_x     = emit ? s_min_x[ch_q] : '0;
    bus.o_max_x     = emit ? s_max_x[ch_q] : '0;
    bus.o_min_y     = emit ? s_min_y[ch_q] : '0;
    bus.o_max_y     = emit ? s_max_y[ch_q] : '0;
`ifdef CENTROID_MEAN_EN
    bus.o_cx        = emit ? cx_q : '0;
    bus.o_cy        = emit ? cy_q : '0;
`else
    bus.o_cx        = emit ? mid_x[X_W:1] : '0;
    bus.o_cy        = emit ? mid_y[Y_W:1] : '0;
`endif
    bus.o_overflow  = overflow_q;
  end
endmodule
